// File: rtl/grf_scoreboard_if.sv
// Pipeline-side bundle for the general register file: D-stage read/issue,
// W-stage write-back, and the commit trace / error outputs.
interface grf_scoreboard_if;
    // D-stage read ports
    logic [4:0]  A1_D;
    logic [4:0]  A2_D;
    logic [31:0] RD1_D;
    logic [31:0] RD2_D;
    logic        Busy1_D;
    logic        Busy2_D;
    // D-stage destination claim
    logic        Issue_D;
    logic [4:0]  IssueA3_D;
    // W-stage write-back
    logic        WE_W;
    logic [4:0]  A3_W;
    logic [31:0] WD_W;
    logic [31:0] PC_W;
    // Commit trace and scoreboard error
    logic        Trace_V;
    logic [31:0] Trace_PC;
    logic [4:0]  Trace_A3;
    logic [31:0] Trace_WD;
    logic        Err;

    // Pipeline / hazard-unit side
    modport master (
        output A1_D, A2_D, Issue_D, IssueA3_D, WE_W, A3_W, WD_W, PC_W,
        input  RD1_D, RD2_D, Busy1_D, Busy2_D,
        input  Trace_V, Trace_PC, Trace_A3, Trace_WD, Err
    );

    // Register-file side
    modport slave (
        input  A1_D, A2_D, Issue_D, IssueA3_D, WE_W, A3_W, WD_W, PC_W,
        output RD1_D, RD2_D, Busy1_D, Busy2_D,
        output Trace_V, Trace_PC, Trace_A3, Trace_WD, Err
    );
endinterface

// File: rtl/grf_scoreboard.sv
// 32 x 32-bit general register file with W->D bypass, a per-register
// pending-write counter scoreboard, and a one-cycle commit trace.
module grf_scoreboard #(
    parameter int unsigned CNT_W     = 2,
    parameter logic [31:0] RESET_VAL = 32'h0
) (
    input logic              clk,
    input logic              reset,
    grf_scoreboard_if.slave  bus
);

    localparam logic [CNT_W-1:0] CntMax = '1;
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    // Entry 0 exists only so every 5-bit index is in range; it stays zero.
    logic [31:0]      regs_q [32];
    logic [CNT_W-1:0] cnt_q  [32];
    logic [CNT_W-1:0] cnt_d  [32];
    logic             err_q;
    logic             err_d;

    logic             trace_v_q;
    logic [31:0]      trace_pc_q;
    logic [4:0]       trace_a3_q;
    logic [31:0]      trace_wd_q;

    logic             wr_en;
    logic [31:0]      rd1;
    logic [31:0]      rd2;
    logic             busy1;
    logic             busy2;

    assign wr_en = bus.WE_W && (bus.A3_W != 5'd0);

    // Read ports: $0 is hard zero, a same-cycle write to the address is bypassed.
    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (bus.A1_D != 5'd0) begin
            rd1 = (wr_en && (bus.A3_W == bus.A1_D)) ? bus.WD_W : regs_q[bus.A1_D];
        end
        if (bus.A2_D != 5'd0) begin
            rd2 = (wr_en && (bus.A3_W == bus.A2_D)) ? bus.WD_W : regs_q[bus.A2_D];
        end
    end

    // Busy: pending count minus a retire happening this cycle is nonzero.
    // A retire against an empty counter still reads busy (count goes negative).
    always_comb begin
        busy1 = 1'b0;
        busy2 = 1'b0;
        if (bus.A1_D != 5'd0) begin
            if (bus.WE_W && (bus.A3_W == bus.A1_D)) begin
                busy1 = (cnt_q[bus.A1_D] != CntOne);
            end else begin
                busy1 = (cnt_q[bus.A1_D] != '0);
            end
        end
        if (bus.A2_D != 5'd0) begin
            if (bus.WE_W && (bus.A3_W == bus.A2_D)) begin
                busy2 = (cnt_q[bus.A2_D] != CntOne);
            end else begin
                busy2 = (cnt_q[bus.A2_D] != '0);
            end
        end
    end

    // Counter next state: issue adds, retire subtracts, both cancel; saturate and flag.
    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        cnt_d[0] = '0;
        for (int r = 1; r < 32; r++) begin
            logic inc;
            logic dec;
            inc = bus.Issue_D && (bus.IssueA3_D == 5'(r));
            dec = bus.WE_W && (bus.A3_W == 5'(r));
            if (inc && !dec) begin
                if (cnt_q[r] == CntMax) begin
                    err_d = 1'b1;
                end else begin
                    cnt_d[r] = cnt_q[r] + CntOne;
                end
            end else if (dec && !inc) begin
                if (cnt_q[r] == '0) begin
                    err_d = 1'b1;
                end else begin
                    cnt_d[r] = cnt_q[r] - CntOne;
                end
            end
        end
    end

    // Register array, scoreboard counters and sticky error flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < 32; r++) begin
                regs_q[r] <= (r == 0) ? 32'h0 : RESET_VAL;
                cnt_q[r]  <= '0;
            end
            err_q <= 1'b0;
        end else begin
            if (wr_en) begin
                regs_q[bus.A3_W] <= bus.WD_W;
            end
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    // Commit trace: pulse for one cycle per write, payload holds between writes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            trace_v_q  <= 1'b0;
            trace_pc_q <= '0;
            trace_a3_q <= '0;
            trace_wd_q <= '0;
        end else begin
            trace_v_q <= wr_en;
            if (wr_en) begin
                trace_pc_q <= bus.PC_W;
                trace_a3_q <= bus.A3_W;
                trace_wd_q <= bus.WD_W;
            end
        end
    end

    assign bus.RD1_D    = rd1;
    assign bus.RD2_D    = rd2;
    assign bus.Busy1_D  = busy1;
    assign bus.Busy2_D  = busy2;
    assign bus.Trace_V  = trace_v_q;
    assign bus.Trace_PC = trace_pc_q;
    assign bus.Trace_A3 = trace_a3_q;
    assign bus.Trace_WD = trace_wd_q;
    assign bus.Err      = err_q;

endmodule
